// File: rtl/grey_pkg.sv
// Shared types and helpers for grey-code consumers: FSM state encoding and grey->binary decode.
package grey_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        LOCK  = 2'd1,
        TRACK = 2'd2
    } state_e;

    // Input must be zero-extended from the real width; each binary bit is the
    // XOR of all grey bits at or above it, so upper zeros leave it unchanged.
    function automatic logic [31:0] grey2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/grey_sync_chain.sv
// Multi-flop synchronizer for a grey bus crossing into clk; resets to all-zero.
module grey_sync_chain #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             w_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // First stage samples d directly: no logic may precede it.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/grey_decode6.sv
// Synchronizes an asynchronous grey counter, decodes it, and flags legal +1 steps vs illegal jumps.
module grey_decode6
    import grey_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 w_reset,
    input  logic [WIDTH-1:0]     grey_in,
    input  logic                 clr_err,
    output logic                 valid,
    output logic [WIDTH-1:0]     bin,
    output logic                 step,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    state_e           state;
    logic [CNT_W-1:0] flush_cnt;
    logic [WIDTH-1:0] g_sync;
    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] bin_dec;
    logic             changed;
    logic             is_step;
    logic             step_nx;
    logic             err_nx;

    grey_sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .w_reset (w_reset),
        .d       (grey_in),
        .q       (g_sync)
    );

    assign bin_dec = WIDTH'(grey2bin(32'(g_sync)));
    assign changed = (g_sync != g_prev);
    assign is_step = changed && (bin_dec == bin + WIDTH'(1));
    assign step_nx = (state == TRACK) && is_step;
    assign err_nx  = (state == TRACK) && changed && !is_step;

    // FLUSH waits until the chain holds post-reset samples, so LOCK's baseline is real.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            g_prev    <= '0;
            bin       <= '0;
            valid     <= 1'b0;
            step      <= 1'b0;
            err       <= 1'b0;
        end else begin
            step <= step_nx;
            err  <= err_nx;
            case (state)
                FLUSH: begin
                    if (flush_cnt == CNT_W'(SYNC_STAGES)) begin
                        state <= LOCK;
                    end else begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                LOCK: begin
                    g_prev <= g_sync;
                    bin    <= bin_dec;
                    valid  <= 1'b1;
                    state  <= TRACK;
                end
                TRACK: begin
                    // Legal or not, any new code becomes the new reference.
                    if (changed) begin
                        g_prev <= g_sync;
                        bin    <= bin_dec;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_reset) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= err_nx ? ERR_CNT_W'(1) : '0;
        end else if (err_nx && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_grey_decode6.sv
// Randomized and directed bench for grey_decode6 against a binary-domain reference model.
module tb_grey_decode6;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         w_reset;
    logic         clr_err;
    logic [W-1:0] grey_in;

    logic         valid_a, step_a, err_a;
    logic [W-1:0] bin_a;
    logic [7:0]   cnt_a;
    logic         valid_b, step_b, err_b;
    logic [W-1:0] bin_b;
    logic [1:0]   cnt_b;

    always #5 clk = ~clk;

    grey_decode6 #(.WIDTH(W), .SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .w_reset(w_reset), .grey_in(grey_in), .clr_err(clr_err),
        .valid(valid_a), .bin(bin_a), .step(step_a), .err(err_a), .err_cnt(cnt_a)
    );

    grey_decode6 #(.WIDTH(W), .SYNC_STAGES(2), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .w_reset(w_reset), .grey_in(grey_in), .clr_err(clr_err),
        .valid(valid_b), .bin(bin_b), .step(step_b), .err(err_b), .err_cnt(cnt_b)
    );

    int          tests = 0;
    int          fails = 0;
    int unsigned cur_bin = 0;
    bit          chk_en = 0;
    int          step_seen = 0;
    int          err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic set_bin(input int unsigned b);
        cur_bin = b % 64;
        grey_in = W'(cur_bin ^ (cur_bin >> 1));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference model: works on the binary value being driven, delayed by the
    // synchronizer depth; a legal move is exactly +1 mod 64.
    int unsigned q[$];
    int          n_edges = 0;
    bit          m_valid = 0, m_step = 0, m_err = 0;
    int unsigned m_bin = 0, m_cnt8 = 0, m_cnt2 = 0;

    always @(posedge clk) begin
        int unsigned seen;
        if (w_reset) begin
            n_edges = 0; q.delete();
            m_valid = 0; m_bin = 0; m_step = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_step = 0; m_err = 0;
            q.push_back(cur_bin);
            if (q.size() > 3) void'(q.pop_front());
            if (n_edges < 4) n_edges++;
            seen = q[0];
            if (!m_valid) begin
                if (n_edges == 4) begin
                    m_valid = 1;
                    m_bin   = seen;
                end
            end else if (seen != m_bin) begin
                if (seen == (m_bin + 1) % 64) m_step = 1;
                else m_err = 1;
                m_bin = seen;
            end
            if (clr_err) begin
                m_cnt8 = m_err; m_cnt2 = m_err;
            end else if (m_err) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", valid_a, m_valid);
            check("bin", bin_a, m_bin);
            check("step", step_a, m_step);
            check("err", err_a, m_err);
            check("err_cnt", cnt_a, m_cnt8);
            check("sat_valid", valid_b, m_valid);
            check("sat_bin", bin_b, m_bin);
            check("sat_step", step_b, m_step);
            check("sat_err", err_b, m_err);
            check("sat_err_cnt", cnt_b, m_cnt2);
            if (step_a) step_seen++;
            if (err_a) err_seen++;
        end
    end

    initial begin
        int s0, e0, r;
        w_reset = 1'b1;
        clr_err = 1'b0;
        set_bin(0);
        tick(2);
        chk_en  = 1;
        w_reset = 1'b0;

        // Baseline capture timing
        tick(3);
        check("lock_not_yet", valid_a, 0);
        tick(1);
        check("lock_valid", valid_a, 1);
        check("lock_bin", bin_a, 0);
        check("lock_no_err", err_a, 0);

        // Full walk with wrap
        s0 = step_seen;
        for (int i = 1; i <= 64; i++) begin
            set_bin(i);
            tick(4);
        end
        check("walk_steps", step_seen - s0, 64);
        check("walk_bin", bin_a, 0);
        check("walk_err_cnt", cnt_a, 0);

        // Jump 5 -> 0
        for (int i = 1; i <= 5; i++) begin
            set_bin(i);
            tick(4);
        end
        set_bin(0);
        tick(3);
        check("jump_err", err_a, 1);
        check("jump_step", step_a, 0);
        check("jump_bin", bin_a, 0);
        check("jump_cnt", cnt_a, 1);
        tick(1);
        check("jump_err_pulse", err_a, 0);

        // Backward 5 -> 4
        for (int i = 1; i <= 5; i++) begin
            set_bin(i);
            tick(4);
        end
        set_bin(4);
        tick(3);
        check("back_err", err_a, 1);
        check("back_step", step_a, 0);
        check("back_bin", bin_a, 4);
        check("back_cnt", cnt_a, 2);

        // Saturation on the 2-bit counter, then clear coincident with an error
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_cnt", cnt_a, 0);
        check("clr_sat_cnt", cnt_b, 0);
        for (int i = 0; i < 5; i++) begin
            set_bin((i % 2 == 0) ? 10 : 30);
            tick(4);
        end
        check("five_err_cnt", cnt_a, 5);
        check("sat_cnt", cnt_b, 3);
        set_bin(30);
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_with_err", err_b, 1);
        check("clr_with_err_cnt", cnt_a, 1);
        check("clr_with_err_sat", cnt_b, 1);

        // Reset mid-operation with input held at 20
        set_bin(20);
        tick(6);
        check("pre_reset_bin", bin_a, 20);
        e0 = err_seen;
        w_reset = 1'b1;
        tick(1);
        check("rst_valid", valid_a, 0);
        check("rst_bin", bin_a, 0);
        check("rst_cnt", cnt_a, 0);
        w_reset = 1'b0;
        tick(3);
        check("relock_not_yet", valid_a, 0);
        tick(1);
        check("relock_valid", valid_a, 1);
        check("relock_bin", bin_a, 20);
        tick(2);
        check("relock_no_err", err_seen - e0, 0);

        // Steady input: no pulses
        s0 = step_seen;
        e0 = err_seen;
        tick(50);
        check("steady_steps", step_seen - s0, 0);
        check("steady_errs", err_seen - e0, 0);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
            end else if (r < 80) set_bin(cur_bin + 1);
            else if (r < 90) set_bin(cur_bin + 63);
            else set_bin($urandom_range(0, 63));
            clr_err = ($urandom_range(0, 39) == 0);
            w_reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        w_reset = 1'b0;
        clr_err = 1'b0;
        tick(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
